// File: rtl/neuron_core_wb_slave.sv
// Wishbone slave front-end of the neuron core: maps bus cycles onto synapse DFFRAM, parameter registers or spike word.
// Latency: writes and register/spike reads ack one cycle after the request, RAM reads two; the bus is never left hanging.
module neuron_core_wb_slave #(
    parameter logic [31:0] PARAM_RST = 32'h0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        synap_matrix,
    input  logic        param,
    input  logic        neuron_spike_out,
    input  logic [4:0]  param_num,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] spike_i,
    output logic [31:0] param0_o,
    output logic [31:0] param1_o,
    output logic [31:0] param2_o,
    output logic        param_upd_o
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic              upd_q, upd_d;
    logic [31:0]       dat_q, dat_d;
    logic [2:0][31:0]  param_q, param_d;

    logic       req;
    logic       idle_req;
    logic [1:0] param_idx;
    logic       unused_ok;

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign idle_req  = (state_q == IDLE) & req;
    assign param_idx = wbs_adr_i[3:2];

    // RAM strobes are only driven while the request is being accepted; gated by reset so they drop immediately.
    assign ram_en    = wb_rst_n & idle_req & synap_matrix;
    assign ram_we    = (wb_rst_n & idle_req & synap_matrix & wbs_we_i) ? wbs_sel_i : 4'h0;
    assign ram_addr  = wbs_adr_i[9:2];
    assign ram_wdata = wbs_dat_i;

    assign unused_ok = ^{param_num, wbs_adr_i[31:10], wbs_adr_i[1:0]};

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        param_d = param_q;
        upd_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACK;
                    if (synap_matrix) begin
                        if (!wbs_we_i) state_d = RD_WAIT;
                    end else if (param) begin
                        if (wbs_we_i) begin
                            upd_d = 1'b1;
                            for (int i = 0; i < 3; i++) begin
                                if (param_idx == 2'(i)) begin
                                    for (int k = 0; k < 4; k++) begin
                                        if (wbs_sel_i[k]) param_d[i][8*k +: 8] = wbs_dat_i[8*k +: 8];
                                    end
                                end
                            end
                        end else begin
                            dat_d = 32'h0;
                            for (int i = 0; i < 3; i++) begin
                                if (param_idx == 2'(i)) dat_d = param_q[i];
                            end
                        end
                    end else if (neuron_spike_out) begin
                        if (!wbs_we_i) dat_d = spike_i;
                    end else begin
                        if (!wbs_we_i) dat_d = 32'h0;
                    end
                end
            end
            RD_WAIT: begin
                // Master gave up the cycle: drop the read without acking.
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    dat_d   = ram_rdata;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == ACK);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            upd_q   <= 1'b0;
            dat_q   <= 32'h0;
            param_q <= {3{PARAM_RST}};
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            upd_q   <= upd_d;
            dat_q   <= dat_d;
            param_q <= param_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign param_upd_o = upd_q;
    assign param0_o    = param_q[0];
    assign param1_o    = param_q[1];
    assign param2_o    = param_q[2];

endmodule

// File: tb/tb_neuron_core_wb_slave.sv
// Directed bench for neuron_core_wb_slave: table of bus transfers plus reset and abort sequences.
module tb_neuron_core_wb_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] dat_o;
    logic        s_syn, s_par, s_spk;
    logic [4:0]  pnum;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] spike;
    logic [31:0] p0, p1, p2;
    logic        upd;

    logic [31:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    neuron_core_wb_slave #(.PARAM_RST(32'h0)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .synap_matrix(s_syn), .param(s_par), .neuron_spike_out(s_spk), .param_num(pnum),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .spike_i(spike),
        .param0_o(p0), .param1_o(p1), .param2_o(p2), .param_upd_o(upd)
    );

    // Decoder model: adr[15:13] selects 0 synapse, 1 param, 2 spike, others unmapped.
    always_comb begin
        s_syn = (adr[15:13] == 3'd0);
        s_par = (adr[15:13] == 3'd1);
        s_spk = (adr[15:13] == 3'd2);
        pnum  = {3'b0, adr[3:2]};
    end

    // Synchronous DFFRAM model with byte enables, data one cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int k = 0; k < 4; k++)
                if (ram_we[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] spike;
        int          lat;
        logic [31:0] rdat;
        logic        en;
        logic [3:0]  rwe;
        logic        upd;
        logic [31:0] p0, p1, p2;
    } vec_t;

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rd, output logic en_s,
                        output logic [3:0] we_s, output logic [7:0] addr_s, output logic upd_s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        #1;
        en_s = ram_en; we_s = ram_we; addr_s = ram_addr;
        lat = 0; rd = 32'h0; upd_s = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = c; rd = dat_o; upd_s = upd;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_single_pulse", {31'b0, ack}, 32'h0);
    endtask

    vec_t vecs[15];
    int          lat;
    logic [31:0] rd;
    logic        en_s, upd_s;
    logic [3:0]  we_s;
    logic [7:0]  addr_s;
    int          acks;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 32'hC000_6000; wdat = 0; spike = 0;
        //            we  adr           wdat          sel    spike  lat rdat          en rwe   upd p0            p1            p2
        vecs[0]  = '{1, 32'hC000_2008, 32'hDEADBEEF, 4'h5, 32'h0, 1, 32'h0,        0, 4'h0, 1, 32'h0,        32'h0,        32'h00AD00EF};
        vecs[1]  = '{0, 32'hC000_2008, 32'h0,        4'hF, 32'h0, 1, 32'h00AD00EF, 0, 4'h0, 0, 32'h0,        32'h0,        32'h00AD00EF};
        vecs[2]  = '{1, 32'hC000_2000, 32'h11223344, 4'hF, 32'h0, 1, 32'h0,        0, 4'h0, 1, 32'h11223344, 32'h0,        32'h00AD00EF};
        vecs[3]  = '{1, 32'hC000_2004, 32'hAABBCCDD, 4'h8, 32'h0, 1, 32'h0,        0, 4'h0, 1, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[4]  = '{1, 32'hC000_2004, 32'h55555555, 4'h0, 32'h0, 1, 32'h0,        0, 4'h0, 1, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[5]  = '{0, 32'hC000_2000, 32'h0,        4'hF, 32'h0, 1, 32'h11223344, 0, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[6]  = '{1, 32'hC000_03FC, 32'h12345678, 4'hF, 32'h0, 1, 32'h0,        1, 4'hF, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[7]  = '{0, 32'hC000_03FC, 32'h0,        4'hF, 32'h0, 2, 32'h12345678, 1, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[8]  = '{1, 32'hC000_0010, 32'hCAFEF00D, 4'h3, 32'h0, 1, 32'h0,        1, 4'h3, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[9]  = '{0, 32'hC000_0010, 32'h0,        4'hF, 32'h0, 2, 32'h0000F00D, 1, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[10] = '{0, 32'hC000_4000, 32'h0,        4'hF, 32'hA5, 1, 32'h000000A5, 0, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[11] = '{1, 32'hC000_4000, 32'hFFFFFFFF, 4'hF, 32'hA5, 1, 32'h0,       0, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[12] = '{0, 32'hC000_6000, 32'h0,        4'hF, 32'hA5, 1, 32'h0,       0, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[13] = '{1, 32'hC000_6000, 32'h87654321, 4'hF, 32'hA5, 1, 32'h0,       0, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};
        vecs[14] = '{0, 32'hC000_2008, 32'h0,        4'hF, 32'hA5, 1, 32'h00AD00EF, 0, 4'h0, 0, 32'h11223344, 32'hAA000000, 32'h00AD00EF};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_upd", {31'b0, upd}, 32'h0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
        chk("rst_p0", p0, 32'h0);
        chk("rst_p1", p1, 32'h0);
        chk("rst_p2", p2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            spike = vecs[i].spike;
            xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel, lat, rd, en_s, we_s, addr_s, upd_s);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_ram_en", i), {31'b0, en_s}, {31'b0, vecs[i].en});
            chk($sformatf("v%0d_ram_we", i), {28'b0, we_s}, {28'b0, vecs[i].rwe});
            chk($sformatf("v%0d_ram_addr", i), {24'b0, addr_s}, {24'b0, vecs[i].adr[9:2]});
            chk($sformatf("v%0d_upd", i), {31'b0, upd_s}, {31'b0, vecs[i].upd});
            if (!vecs[i].we) chk($sformatf("v%0d_rdat", i), rd, vecs[i].rdat);
            chk($sformatf("v%0d_p0", i), p0, vecs[i].p0);
            chk($sformatf("v%0d_p1", i), p1, vecs[i].p1);
            chk($sformatf("v%0d_p2", i), p2, vecs[i].p2);
        end

        // Abort: master drops the cycle while the RAM read is outstanding.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hC000_03FC; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("abort_no_ack", acks, 0);
        xfer(1'b0, 32'hC000_2000, 32'h0, 4'hF, lat, rd, en_s, we_s, addr_s, upd_s);
        chk("after_abort_lat", lat, 1);
        chk("after_abort_rdat", rd, 32'h11223344);

        // Reset asserted while a RAM read sits in RD_WAIT.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hC000_03FC; sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", {31'b0, ack}, 32'h0);
        chk("midrst_ram_en", {31'b0, ram_en}, 32'h0);
        chk("midrst_p0", p0, 32'h0);
        chk("midrst_p1", p1, 32'h0);
        chk("midrst_p2", p2, 32'h0);
        chk("midrst_dat", dat_o, 32'h0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("midrst_lost", acks, 0);
        xfer(1'b0, 32'hC000_03FC, 32'h0, 4'hF, lat, rd, en_s, we_s, addr_s, upd_s);
        chk("post_rst_ram_lat", lat, 2);
        chk("post_rst_ram_rdat", rd, 32'h12345678);
        xfer(1'b0, 32'hC000_2008, 32'h0, 4'hF, lat, rd, en_s, we_s, addr_s, upd_s);
        chk("post_rst_p2_rdat", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_core_wb_slave.md
# neuron_core_wb_slave

Wishbone slave front-end of the neuron core: it consumes the one-hot region strobes produced combinationally by the neuron-core address decoder from `wbs_adr_i` and turns each bus cycle into the correct downstream action. Actions are a synapse-matrix DFFRAM access, a parameter-register access or a spike-word read. The block owns the bus handshake and the read-latency sequencing, and holds the three core parameter registers. It sits between the Caravel Wishbone bus and the synapse DFFRAM / neuron datapath.

## Interface
- `PARAM_RST`, default `32'h0`: reset value of all three parameter registers.

Ports:
- `wb_clk_i`  in  1  core clock; all state changes on the rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle, strobe and write-enable.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address; also drives the decoder.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge; registered, one-cycle pulse.
- `wbs_dat_o`  out  32  read data; registered.
- `synap_matrix`, `param`, `neuron_spike_out`  in  1 each  decoder region strobes; combinational from `wbs_adr_i`, at most one high.
- `param_num`  in  5  decoder parameter index; accepted but unused, because `param_idx` comes from `wbs_adr_i[3:2]`.
- `ram_en`  out  1  DFFRAM enable.
- `ram_we`  out  4  DFFRAM byte write enables.
- `ram_addr`  out  8  DFFRAM word address, equal to `wbs_adr_i[9:2]`.
- `ram_wdata`  out  32  DFFRAM write data.
- `ram_rdata`  in  32  DFFRAM read data; valid the cycle after `ram_en`.
- `spike_i`  in  32  live neuron spike word.
- `param0_o`, `param1_o`, `param2_o`  out  32 each  parameter registers.
- `param_upd_o`  out  1  one-cycle pulse in the cycle after any parameter-register write.

## Operation
- Request: `req = wbs_cyc_i & wbs_stb_i`, sampled only in state IDLE.
- FSM states: IDLE, RD_WAIT, ACK. The reset state is IDLE.
- IDLE with `req`:
  - `synap_matrix & ~wbs_we_i`: drive `ram_en=1`, `ram_we=0` combinationally. Go to RD_WAIT.
  - `synap_matrix & wbs_we_i`: drive `ram_en=1`, `ram_we=wbs_sel_i`, `ram_wdata=wbs_dat_i` combinationally. Go to ACK.
  - `param`, write: update register `param_idx = wbs_adr_i[3:2]` (values 0..2) byte-wise per `wbs_sel_i`. Go to ACK.
  - `param`, read: load `wbs_dat_o` with the selected register. Go to ACK.
  - `neuron_spike_out`, read: load `wbs_dat_o <= spike_i`. Go to ACK.
  - `neuron_spike_out`, write: no side effect. Go to ACK.
  - No strobe (unmapped): load `wbs_dat_o <= 0`. Go to ACK. Unmapped reads return 0 and unmapped writes are dropped; the bus never hangs.
- RD_WAIT:
  - Load `wbs_dat_o <= ram_rdata`. Go to ACK.
  - If `wbs_cyc_i=0`, abort: go to IDLE and assert no ack.
- ACK: `wbs_ack_o=1` for exactly this cycle, then go to IDLE.
- Outside IDLE, `ram_en` and `ram_we` are 0; `ram_addr` and `ram_wdata` always follow the bus.
- `wbs_dat_o` holds its value until the next read loads it.

## Timing
- Request sampled at cycle T.
- Write latency: the side effect happens at T (RAM write strobe, or parameter register updated at the T edge). `wbs_ack_o` is high at T+1. `param_upd_o` is high at T+1.
- Register/spike read latency: `wbs_dat_o` and `wbs_ack_o` are valid at T+1.
- RAM read latency: `ram_en` at T, `ram_rdata` at T+1, `wbs_dat_o` and `wbs_ack_o` at T+2.
- Back-to-back transfers: the next request can be sampled no earlier than the cycle after ACK. A `stb` still high during the ACK cycle is not a new request.
- `spike_i` is sampled in cycle T; a change at T+1 is not reflected.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `wbs_ack_o=0` and `wbs_dat_o=0`.
  - `ram_en=0` and `ram_we=0`.
  - `param_upd_o=0`.
  - `param0_o`, `param1_o`, `param2_o` = `PARAM_RST`.
  - An in-flight transfer is lost without ack.
- Byte writes: bytes with `wbs_sel_i[k]=0` keep their old value. `wbs_sel_i=0` acks with no change.

## Test plan
- Reset: assert `wb_rst_n=0` mid RD_WAIT -> `wbs_ack_o=0`, `ram_en=0`, all params `32'h0`. After release, the first request is serviced normally.
- Param write/read: write `32'hDEADBEEF` with sel `4'b0101` to `0xC000_2008` -> `param2_o=32'h00AD00EF`, ack at T+1, `param_upd_o` at T+1. Read back -> `wbs_dat_o=32'h00AD00EF`.
- Synapse RAM: write `32'h12345678` to `0xC000_03FC` -> `ram_addr=8'hFF`, `ram_we=4'hF` at T. Read back -> ack at T+2 with the same data.
- Spike read: `spike_i=32'h0000_00A5`, read `0xC000_4000` -> `wbs_dat_o=32'hA5`, ack at T+1. A write to the same address leaves `spike_i` and the params unchanged and still acks.
- Unmapped address `0xC000_6000`, read and write -> ack at T+1, data 0, no `ram_en`, no param change.
- Abort: drop `wbs_cyc_i` during RD_WAIT -> no ack, FSM back in IDLE. A following read returns correct data.
